// File: rtl/multi_port_regfile.sv
// Two-read / one-write register file with a sequential clear sweep.
// Optional feature: define REGFILE_BYPASS_EN to forward an accepted write to same-cycle reads.
module multi_port_regfile #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [ADDR_W-1:0] RS,
  input  logic [ADDR_W-1:0] RT,
  input  logic [ADDR_W-1:0] RD,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              RegWrite,
  input  logic              ClearReq,
  output logic [DATA_W-1:0] ReadRS,
  output logic [DATA_W-1:0] ReadRT,
  output logic              Busy,
  output logic              WriteDropped
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              wdrop_q, wdrop_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              wr_hit_zero;
  logic              wr_accept;

  // Writes to the hardwired zero entry vanish silently; they are not "dropped".
  assign wr_hit_zero = ZERO_REG && (RD == '0);
  assign wr_accept   = RegWrite && (state_q == IDLE) && !wr_hit_zero;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wdrop_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (ClearReq) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        wdrop_d = RegWrite;
        if (cnt_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
        end
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // A write and a sweep step are never active in the same cycle.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_accept && (RD == ADDR_W'(i))) begin
        mem_d[i] = WriteData;
      end
      if ((state_q == CLEAR) && (cnt_q == ADDR_W'(i))) begin
        mem_d[i] = '0;
      end
    end
    if (ZERO_REG) begin
      mem_d[0] = '0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wdrop_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wdrop_q <= wdrop_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    ReadRS = mem_q[RS];
    if (ZERO_REG && (RS == '0)) begin
      ReadRS = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (RD == RS)) begin
      ReadRS = WriteData;
    end
`endif
  end

  always_comb begin
    ReadRT = mem_q[RT];
    if (ZERO_REG && (RT == '0)) begin
      ReadRT = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_accept && (RD == RT)) begin
      ReadRT = WriteData;
    end
`endif
  end

  assign Busy         = (state_q == CLEAR);
  assign WriteDropped = wdrop_q;

endmodule

// File: tb/tb_multi_port_regfile.sv
// Self-checking bench for multi_port_regfile: directed vector table, hand sequences,
// and random stimulus against a queue-based model; covers ZERO_REG=0 and ZERO_REG=1.
module tb_multi_port_regfile;

  localparam int DW    = 16;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          Reset, RegWrite, ClearReq;
  logic [AW-1:0] RS, RT, RD;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] rs0, rt0, rsz, rtz;
  logic          busy0, busyz, drop0, dropz;

  multi_port_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dut (
    .Clock(clk), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ClearReq(ClearReq), .ReadRS(rs0), .ReadRT(rt0),
    .Busy(busy0), .WriteDropped(drop0)
  );

  multi_port_regfile #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dut_z (
    .Clock(clk), .Reset(Reset), .RS(RS), .RT(RT), .RD(RD), .WriteData(WriteData),
    .RegWrite(RegWrite), .ClearReq(ClearReq), .ReadRS(rsz), .ReadRT(rtz),
    .Busy(busyz), .WriteDropped(dropz)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference model: plain storage plus a queue of addresses still waiting to be swept.
  logic [DW-1:0] m  [DEPTH] = '{default: '0};
  logic [DW-1:0] mz [DEPTH] = '{default: '0};
  int            sweep_q[$];
  bit            drop_m   = 1'b0;
  bit            model_ok = 1'b0;

  function automatic logic [DW-1:0] exp_read(input bit zero, input logic [AW-1:0] a);
    logic [DW-1:0] v;
    v = zero ? mz[a] : m[a];
`ifdef REGFILE_BYPASS_EN
    if (RegWrite && (sweep_q.size() == 0) && !(zero && RD == 0) && (RD == a)) v = WriteData;
`endif
    return v;
  endfunction

  task automatic model_check();
    bit busy_m;
    if (!model_ok) return;
    busy_m = (sweep_q.size() != 0);
    chk("m.ReadRS",       rs0,   exp_read(1'b0, RS));
    chk("m.ReadRT",       rt0,   exp_read(1'b0, RT));
    chk("m.z.ReadRS",     rsz,   exp_read(1'b1, RS));
    chk("m.z.ReadRT",     rtz,   exp_read(1'b1, RT));
    chk("m.Busy",         busy0, busy_m);
    chk("m.z.Busy",       busyz, busy_m);
    chk("m.WriteDropped", drop0, drop_m);
    chk("m.z.WriteDrop",  dropz, drop_m);
  endtask

  task automatic model_update();
    int a;
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m[i]  = '0;
        mz[i] = '0;
      end
      sweep_q.delete();
      drop_m   = 1'b0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      drop_m = RegWrite && (sweep_q.size() != 0);
      if (sweep_q.size() != 0) begin
        a     = sweep_q.pop_front();
        m[a]  = '0;
        mz[a] = '0;
      end else begin
        if (RegWrite) begin
          m[RD] = WriteData;
          if (RD != 0) mz[RD] = WriteData;
        end
        if (ClearReq) begin
          for (int i = 0; i < DEPTH; i++) sweep_q.push_back(i);
        end
      end
    end
  endtask

  task automatic drive(input logic rst, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                       input logic [AW-1:0] rd, input logic [DW-1:0] wd,
                       input logic we, input logic clr);
    Reset = rst; RS = rs; RT = rt; RD = rd; WriteData = wd; RegWrite = we; ClearReq = clr;
    #1;
    $display("cyc %0d rst=%0b rs=%0d rt=%0d rd=%0d wd=%h we=%0b clr=%0b | rs=%h rt=%h busy=%0b drop=%0b",
             cyc, rst, rs, rt, rd, wd, we, clr, rs0, rt0, busy0, drop0);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
  endtask

  typedef struct {
    logic          rst;
    logic [AW-1:0] rs, rt, rd;
    logic [DW-1:0] wd;
    logic          we, clr;
    bit            chk;
    logic [DW-1:0] ers, ert;
    logic          ebusy, edrop;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic rst, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                     input logic [AW-1:0] rd, input logic [DW-1:0] wd, input logic we,
                     input logic clr, input bit c, input logic [DW-1:0] ers,
                     input logic [DW-1:0] ert, input logic eb, input logic ed);
    vec_t v;
    v.rst = rst; v.rs = rs; v.rt = rt; v.rd = rd; v.wd = wd; v.we = we; v.clr = clr;
    v.chk = c; v.ers = ers; v.ert = ert; v.ebusy = eb; v.edrop = ed;
    tbl.push_back(v);
  endtask

  logic [DW-1:0] exp_v;

  initial begin
    Reset = 1'b1; RS = '0; RT = '0; RD = '0; WriteData = '0; RegWrite = 1'b0; ClearReq = 1'b0;

    //  rst rs rt rd wd       we clr chk ReadRS   ReadRT   busy drop
    add(1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 1, 2, 16'hA5A5, 1, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 2, 1, 0, 16'h0000, 0, 0, 1, 16'hA5A5, 16'h0000, 0, 0);
    add(0, 2, 2, 0, 16'h0001, 1, 0, 1, 16'hA5A5, 16'hA5A5, 0, 0);
    add(0, 0, 0, 1, 16'h0002, 1, 0, 1, 16'h0001, 16'h0001, 0, 0);
    add(0, 1, 1, 2, 16'h0003, 1, 0, 1, 16'h0002, 16'h0002, 0, 0);
    add(0, 2, 2, 3, 16'h0004, 1, 0, 1, 16'h0003, 16'h0003, 0, 0);
    add(0, 3, 0, 0, 16'h0000, 0, 1, 1, 16'h0004, 16'h0001, 0, 0);
    add(0, 3, 0, 0, 16'h0000, 0, 0, 1, 16'h0004, 16'h0001, 1, 0);
    add(0, 3, 0, 1, 16'h1234, 1, 0, 1, 16'h0004, 16'h0000, 1, 0);
    add(0, 3, 1, 0, 16'h0000, 0, 1, 1, 16'h0004, 16'h0000, 1, 1);
    add(0, 3, 2, 0, 16'h0000, 0, 0, 1, 16'h0004, 16'h0000, 1, 0);
    add(0, 3, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 0, 1, 2, 16'hBEEF, 1, 1, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 2, 2, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 16'hBEEF, 1, 0);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 16'h0000, 1, 0);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 1, 16'hBEEF, 16'h0000, 1, 0);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 1, 0);
    add(0, 2, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 1, 0, 16'hFFFF, 1, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 2, 0, 1, 16'hFFFF, 1, 0, 1, 16'h0000, 16'hFFFF, 0, 0);
    add(0, 3, 1, 2, 16'hFFFF, 1, 0, 1, 16'h0000, 16'hFFFF, 0, 0);
    add(0, 0, 2, 3, 16'hFFFF, 1, 0, 1, 16'hFFFF, 16'hFFFF, 0, 0);
    add(0, 3, 1, 0, 16'h0000, 0, 1, 1, 16'hFFFF, 16'hFFFF, 0, 0);
    add(0, 3, 0, 0, 16'h0000, 0, 0, 1, 16'hFFFF, 16'hFFFF, 1, 0);
    add(1, 3, 1, 1, 16'h1111, 1, 1, 1, 16'hFFFF, 16'hFFFF, 1, 0);
    add(0, 3, 2, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);
    add(0, 1, 0, 0, 16'h0000, 0, 0, 1, 16'h0000, 16'h0000, 0, 0);

    @(negedge clk);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].rs, tbl[i].rt, tbl[i].rd, tbl[i].wd, tbl[i].we, tbl[i].clr);
      if (tbl[i].chk) begin
        chk("t.ReadRS",       rs0,   tbl[i].ers);
        chk("t.ReadRT",       rt0,   tbl[i].ert);
        chk("t.Busy",         busy0, tbl[i].ebusy);
        chk("t.WriteDropped", drop0, tbl[i].edrop);
      end
      advance();
    end

    // Hardwired zero entry: write to entry 0 is discarded without a drop pulse.
    drive(0, 0, 0, 0, 16'h00FF, 1, 0);
    advance();
    drive(0, 0, 0, 0, 16'h0000, 0, 0);
    chk("z.rd0",     rsz,   16'h0000);
    chk("z.nodrop",  dropz, 1'b0);
    chk("rd0",       rs0,   16'h00FF);
    advance();

    // Same-cycle read of the entry being written.
    drive(0, 3, 3, 3, 16'h1357, 1, 0);
    advance();
    drive(0, 3, 3, 3, 16'h0F0F, 1, 0);
`ifdef REGFILE_BYPASS_EN
    exp_v = 16'h0F0F;
`else
    exp_v = 16'h1357;
`endif
    chk("byp.ReadRS", rs0, exp_v);
    chk("byp.ReadRT", rt0, exp_v);
    advance();
    drive(0, 3, 0, 0, 16'hAAAA, 1, 0);
    chk("byp.after", rs0, 16'h0F0F);
`ifdef REGFILE_BYPASS_EN
    exp_v = 16'hAAAA;
`else
    exp_v = 16'h00FF;
`endif
    chk("byp.rt0",   rt0, exp_v);
    chk("byp.z.rt0", rtz, 16'h0000);
    advance();

    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 63) == 0), AW'($urandom_range(0, DEPTH - 1)),
            AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)),
            DW'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0));
      advance();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multi_port_regfile.md
MULTI_PORT_REGFILE -- requirements
Module: multi_port_regfile

Interface
REQ-001 The block SHALL provide parameter DATA_W, default 16, giving the register width in bits.
REQ-002 The block SHALL provide parameter ADDR_W, default 2, giving the address width; DEPTH = 2**ADDR_W entries.
REQ-003 The block SHALL provide parameter ZERO_REG, default 0; when 1, entry 0 is hardwired to zero.
REQ-004 Port Clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 Port Reset, input, 1; reset is synchronous and active-high.
REQ-006 Port RS, input, ADDR_W, first read address.
REQ-007 Port RT, input, ADDR_W, second read address.
REQ-008 Port RD, input, ADDR_W, write address.
REQ-009 Port WriteData, input, DATA_W, write data.
REQ-010 Port RegWrite, input, 1, write enable.
REQ-011 Port ClearReq, input, 1, single-cycle request to start a sequential clear sweep.
REQ-012 Port ReadRS, output, DATA_W, combinational read of entry RS.
REQ-013 Port ReadRT, output, DATA_W, combinational read of entry RT.
REQ-014 Port Busy, output, 1, high while the clear sweep runs.
REQ-015 Port WriteDropped, output, 1, registered one-cycle pulse flagging a rejected write.

Function
REQ-016 A write SHALL occur only when RegWrite=1 and state is IDLE; entry RD takes WriteData at the rising edge.
REQ-017 RegWrite=0 SHALL leave every entry unchanged.
REQ-018 With ZERO_REG=1, writes to entry 0 SHALL be discarded without a WriteDropped pulse, and reads of entry 0 SHALL return 0.
REQ-019 The block SHALL use a two-state FSM: IDLE and CLEAR.
REQ-020 In IDLE, ClearReq=1 SHALL move the FSM to CLEAR and load sweep counter = 0 at the next edge.
REQ-021 In CLEAR, each cycle SHALL write 0 to entry[counter], then increment the counter.
REQ-022 When counter = DEPTH-1 in CLEAR, that entry SHALL be zeroed and the FSM SHALL return to IDLE. The sweep lasts exactly DEPTH cycles.
REQ-023 Busy SHALL be 1 exactly while the FSM is in CLEAR.
REQ-024 ClearReq asserted while in CLEAR SHALL be ignored and SHALL NOT restart the counter.
REQ-025 RegWrite=1 while in CLEAR SHALL be discarded, and WriteDropped SHALL be 1 in the following cycle.
REQ-026 If ClearReq and RegWrite are both 1 in IDLE, the write SHALL complete and the sweep SHALL start at the same edge; the sweep later clears the written entry.
REQ-027 Reads during CLEAR SHALL return current storage: 0 for entries already swept, the old value for entries not yet swept.
REQ-028 RS and RT SHALL be independent; RS = RT SHALL return identical data on both ports.

Reset
REQ-029 On Reset=1 at a rising edge, all DEPTH entries SHALL become 0 in that single cycle.
REQ-030 On Reset=1 at a rising edge, the FSM SHALL go to IDLE and the counter SHALL become 0.
REQ-031 On Reset=1 at a rising edge, Busy SHALL be 0 and WriteDropped SHALL be 0.
REQ-032 Reset SHALL take priority over ClearReq and RegWrite, including when asserted mid-sweep.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN defined: if a write is accepted per REQ-016 and RD = RS, ReadRS SHALL equal WriteData in the same cycle. The same rule SHALL apply to RT and ReadRT. Bypass SHALL NOT apply to the hardwired zero entry.
REQ-034 Macro REGFILE_BYPASS_EN undefined: reads SHALL show the pre-write value until the edge following the write.

Verification
REQ-035 Reset, write RD=2 WriteData=16'hA5A5, next cycle RS=2 -> ReadRS=16'hA5A5 and ReadRT(RT=1)=16'h0000.
REQ-036 Fill entries 0..3 with 1..4, pulse ClearReq -> Busy high for exactly 4 cycles. During the sweep, entry 3 reads 4 until the fourth cycle; afterwards all read 0.
REQ-037 Pulse ClearReq, then RegWrite=1 RD=1 WriteData=16'h1234 in the next cycle -> write discarded, WriteDropped=1 for one cycle, entry 1 reads 0 after the sweep.
REQ-038 Start a sweep on entries holding 16'hFFFF, assert Reset in the second sweep cycle -> Busy=0 next cycle and all entries read 0.
REQ-039 ZERO_REG=1, write RD=0 WriteData=16'h00FF -> ReadRS(RS=0)=0 and WriteDropped stays 0.
REQ-040 With REGFILE_BYPASS_EN, write RD=RS=3 WriteData=16'h0F0F -> ReadRS=16'h0F0F in the same cycle. Without the macro, ReadRS shows the old value in that cycle.
